// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD constants for the microwave timer path
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [3:0]  BCD_INVALID = 4'hF;
    localparam logic [3:0]  BCD_NINE    = 4'd9;
    localparam logic [3:0]  BCD_FIVE    = 4'd5;
    localparam logic [15:0] MMSS_ZERO   = 16'h0000;
endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: synchroniser plus one-cycle falling-edge event for an async active-low button.
// DEBOUNCE is driven from LOAD_DEBOUNCE_EN by the top; with it the event needs CYCLES low samples first.
module key_edge_sync #(
    parameter int STAGES   = 2,
    parameter bit DEBOUNCE = 1'b0,
    parameter int CYCLES   = 16
) (
    input  logic clk,
    input  logic clearn,
    input  logic din,
    output logic fire
);
    logic [STAGES-1:0] sync;
    always_ff @(posedge clk or negedge clearn)
        if (!clearn) sync <= '1;
        else sync <= {sync[STAGES-2:0], din};
    if (DEBOUNCE) begin : g_db
        localparam int W = $clog2(CYCLES + 2);
        logic [W-1:0] cnt;
        // counter parks one past CYCLES so a held key fires exactly once
        always_ff @(posedge clk or negedge clearn)
            if (!clearn) cnt <= '0;
            else cnt <= sync[STAGES-1] ? '0 : (cnt == W'(CYCLES + 1) ? cnt : cnt + W'(1));
        assign fire = !sync[STAGES-1] && cnt == W'(CYCLES);
    end else begin : g_edge
        logic prev;
        always_ff @(posedge clk or negedge clearn)
            if (!clearn) prev <= 1'b1;
            else prev <= sync[STAGES-1];
        assign fire = prev && !sync[STAGES-1];
    end
endmodule

// File: rtl/timer_digit_countdown.sv
// timer_digit_countdown: shifts keypad digits into an MM:SS BCD register and counts it down on 1 Hz ticks.
// Define LOAD_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable low samples on loadn before a key is taken.
module timer_digit_countdown
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clearn,
    input  logic [3:0]  bcd,
    input  logic        loadn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        tick_1hz,
    output logic [15:0] digits,
    output logic        running,
    output logic        paused,
    output logic        done
);
`ifdef LOAD_DEBOUNCE_EN
    localparam bit LOAD_DB = 1'b1;
`else
    localparam bit LOAD_DB = 1'b0;
`endif
    logic key_ev, start_ev, stop_ev, done_d;
    logic [3:0] d3, d2, d1, d0;
    logic [15:0] dec, shifted, digits_d;
    state_t state, state_d;
    key_edge_sync #(.STAGES(SYNC_STAGES), .DEBOUNCE(LOAD_DB), .CYCLES(DEBOUNCE_CYCLES))
        u_load (.clk(clk), .clearn(clearn), .din(loadn), .fire(key_ev));
    key_edge_sync #(.STAGES(SYNC_STAGES), .DEBOUNCE(1'b0), .CYCLES(DEBOUNCE_CYCLES))
        u_start (.clk(clk), .clearn(clearn), .din(startn), .fire(start_ev));
    key_edge_sync #(.STAGES(SYNC_STAGES), .DEBOUNCE(1'b0), .CYCLES(DEBOUNCE_CYCLES))
        u_stop (.clk(clk), .clearn(clearn), .din(stopn), .fire(stop_ev));
    assign {d3, d2, d1, d0} = digits;
    assign shifted = (key_ev && bcd <= BCD_NINE) ? {digits[11:0], bcd} : digits;
    // sec_tens above 5 is left as entered, so 0:90 runs 90, 89, ... naturally
    always_comb begin
        dec = digits;
        if (d0 != '0) dec[3:0] = d0 - 4'd1;
        else begin
            dec[3:0] = BCD_NINE;
            if (d1 != '0) dec[7:4] = d1 - 4'd1;
            else begin
                dec[7:4] = BCD_FIVE;
                if (d2 != '0) dec[11:8] = d2 - 4'd1;
                else begin
                    dec[11:8]  = BCD_NINE;
                    dec[15:12] = d3 - 4'd1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge clearn)
        if (!clearn) begin
            state  <= IDLE;
            digits <= MMSS_ZERO;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            digits <= digits_d;
            done   <= done_d;
        end
    always_comb begin
        state_d  = state;
        digits_d = digits;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                digits_d = shifted;
                if (start_ev && !stop_ev && shifted != MMSS_ZERO) state_d = RUN;
            end
            RUN:
                if (stop_ev) state_d = PAUSE;
                else if (tick_1hz) begin
                    digits_d = dec;
                    if (dec == MMSS_ZERO) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            PAUSE:
                if (stop_ev) begin
                    state_d  = IDLE;
                    digits_d = MMSS_ZERO;
                end else if (start_ev) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        running = state == RUN;
        paused  = state == PAUSE;
    end
endmodule
